iter_counter: RTL and testbench

- Parametrised iteration counter for shift-add datapath sequencing.
- Successor of the basic load/up-down counter, adding:
  - programmable range [0, limit] and step;
  - wrap, saturate and one-shot modes;
  - start/stop/done control FSM;
  - terminal-count pulse and sticky range-error flag.
- Sits between the multiplier control FSM and the shift/add datapath; the controller configures it with start and sequences on tc/done.

---
 rtl/iter_counter.sv | 166 ++++++++++++++++
 tb/tb_iter_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_counter.sv
// Iteration counter for shift-add sequencing: programmable range [0, limit] and step,
// wrap / saturate / one-shot modes, start-stop-done control, tc pulse and sticky ovf.
module iter_counter #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic              en,
  input  logic              up_down,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      data_in,
  input  logic [N-1:0]      limit,
  input  logic [STEP_W-1:0] step,
  output logic [N-1:0]      data_out,
  output logic              c_end,
  output logic              tc,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [1:0]        state_dbg
);

  // Control handshake: start is accepted only in IDLE, stop only in RUN; both are level
  // inputs sampled on the rising clk edge, with no ready/acknowledge other than busy/done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N:0] ONE = (N+1)'(1);

  state_t              state_q, state_d;
  logic [N-1:0]        cnt_q, cnt_d;
  logic                tc_q, tc_d;
  logic                ovf_q, ovf_d;
  logic [N-1:0]        limit_q;
  logic [STEP_W-1:0]   step_q;
  logic [1:0]          mode_q;
  logic                dir_q;

  logic                wrap_mode, oneshot;
  logic [N:0]          s_ext, lim_ext, cnt_ext, sum_up, adv_ext;
  logic [N-1:0]        adv, bound;
  logic                wrap_evt, clamp_err, first_arr, tc_adv;

  assign wrap_mode = (mode_q == 2'b00);
  assign oneshot   = (mode_q == 2'b10);

  // Advance arithmetic in N+1 bits so the overflow compare never truncates.
  always_comb begin
    s_ext     = (step_q == '0) ? ONE : (N+1)'(step_q);
    lim_ext   = {1'b0, limit_q};
    cnt_ext   = {1'b0, cnt_q};
    sum_up    = cnt_ext + s_ext;
    adv_ext   = cnt_ext;
    wrap_evt  = 1'b0;
    clamp_err = 1'b0;
    if (dir_q) begin
      if (sum_up <= lim_ext) begin
        adv_ext = sum_up;
      end else if (wrap_mode && (s_ext <= lim_ext + ONE)) begin
        adv_ext  = sum_up - lim_ext - ONE;
        wrap_evt = 1'b1;
      end else begin
        adv_ext   = lim_ext;
        clamp_err = wrap_mode;
      end
    end else begin
      if (cnt_ext >= s_ext) begin
        adv_ext = cnt_ext - s_ext;
      end else if (wrap_mode && (s_ext <= lim_ext + ONE)) begin
        adv_ext  = cnt_ext + lim_ext + ONE - s_ext;
        wrap_evt = 1'b1;
      end else begin
        adv_ext   = '0;
        clamp_err = wrap_mode;
      end
    end
    adv       = adv_ext[N-1:0];
    bound     = dir_q ? limit_q : '0;
    first_arr = (adv == bound) && (cnt_q != bound);
    // One-shot leaves RUN after reaching the bound, so any arrival counts as the first.
    if (oneshot) tc_adv = (adv == bound);
    else         tc_adv = wrap_evt | ((!wrap_mode || clamp_err) && first_arr);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      if (data_in > limit_q) begin
        cnt_d = limit_q;
        ovf_d = 1'b1;
      end else begin
        cnt_d = data_in;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          if (data_in > limit) begin
            cnt_d = limit;
            ovf_d = 1'b1;
          end else begin
            cnt_d = data_in;
            ovf_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (oneshot && tc_q) begin
          state_d = S_DONE;
        end else if (en && !load) begin
          cnt_d = adv;
          tc_d  = tc_adv;
          if (clamp_err) ovf_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      limit_q <= '0;
      step_q  <= '0;
      mode_q  <= 2'b00;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      if (state_q == S_IDLE && start) begin
        limit_q <= limit;
        step_q  <= step;
        mode_q  <= (mode == 2'b11) ? 2'b01 : mode;
        dir_q   <= up_down;
      end
    end
  end

  assign data_out  = cnt_q;
  assign c_end     = (cnt_q == '0);
  assign tc        = tc_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_iter_counter.sv
// Directed bench for iter_counter: hand-computed count sequences for each mode,
// load/stop/start priority, clamping, ovf behaviour and reset.
module tb_iter_counter;

  localparam int N      = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop, load, en, up_down;
  logic [1:0]        mode;
  logic [N-1:0]      data_in, limit;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      data_out;
  logic              c_end, tc, busy, done, ovf;
  logic [1:0]        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int exp_tc_q[$];

  iter_counter #(.N(N), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load), .en(en),
    .up_down(up_down), .mode(mode), .data_in(data_in), .limit(limit), .step(step),
    .data_out(data_out), .c_end(c_end), .tc(tc), .busy(busy), .done(done), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic begin_run(input int lim, input int stp, input int md, input int dir, input int din);
    limit   = N'(lim);
    step    = STEP_W'(stp);
    mode    = 2'(md);
    up_down = dir[0];
    data_in = N'(din);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic run_seq(input string tag, input logic exp_busy);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      check({tag, "_data"}, 32'(data_out), 32'(exp_q[i]));
      check({tag, "_tc"}, 32'(tc), 32'(exp_tc_q[i]));
      check({tag, "_cend"}, 32'(c_end), 32'(exp_q[i] == 0));
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; en = 1'b0; up_down = 1'b0;
    mode = 2'b00; data_in = '0; limit = '0; step = '0;
    tick();
    tick();
    check("rst_data", 32'(data_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tc", 32'(tc), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_cend", 32'(c_end), 1);
    check("rst_done", 32'(done), 0);
    rst = 1'b1;
    tick();

    // Wrap up: limit 9, step 3.
    en = 1'b1;
    begin_run(9, 3, 0, 1, 0);
    check("wrap_start_data", 32'(data_out), 0);
    check("wrap_start_busy", 32'(busy), 1);
    exp_q    = '{3, 6, 9, 2, 5, 8, 1};
    exp_tc_q = '{0, 0, 0, 1, 0, 0, 1};
    run_seq("wrap_up", 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("wrap_stop_busy", 32'(busy), 0);

    // Wrap down: limit 9, step 4, start at 2.
    begin_run(9, 4, 0, 0, 2);
    exp_q    = '{8, 4, 0, 6};
    exp_tc_q = '{1, 0, 0, 1};
    run_seq("wrap_dn", 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Saturate down: limit 15, step 2, start at 5.
    begin_run(15, 2, 1, 0, 5);
    check("sat_start_data", 32'(data_out), 5);
    exp_q    = '{3, 1, 0, 0, 0};
    exp_tc_q = '{0, 0, 1, 0, 0};
    run_seq("sat_dn", 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Mode 11 behaves as saturate: up with limit 5, step 3.
    begin_run(5, 3, 3, 1, 0);
    exp_q    = '{3, 5, 5};
    exp_tc_q = '{0, 1, 0};
    run_seq("sat11_up", 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Wrap with step larger than the range clamps and flags ovf.
    begin_run(2, 5, 0, 1, 0);
    exp_q    = '{2, 2};
    exp_tc_q = '{1, 0};
    run_seq("wrap_clamp", 1'b1);
    check("wrap_clamp_ovf", 32'(ovf), 1);
    stop = 1'b1; tick(); stop = 1'b0;

    // One-shot up: limit 4, step 1.
    begin_run(4, 1, 2, 1, 0);
    exp_q    = '{1, 2, 3, 4};
    exp_tc_q = '{0, 0, 0, 1};
    run_seq("oneshot", 1'b1);
    check("oneshot_ovf", 32'(ovf), 0);
    check("oneshot_done_early", 32'(done), 0);
    tick();
    check("oneshot_done", 32'(done), 1);
    check("oneshot_done_busy", 32'(busy), 0);
    check("oneshot_done_data", 32'(data_out), 4);
    check("oneshot_done_tc", 32'(tc), 0);
    tick();
    check("oneshot_idle_done", 32'(done), 0);
    check("oneshot_idle_busy", 32'(busy), 0);
    check("oneshot_idle_data", 32'(data_out), 4);

    // Load beats en; restart clamping and ovf clearing.
    begin_run(9, 1, 0, 1, 0);
    exp_q    = '{1, 2, 3};
    exp_tc_q = '{0, 0, 0};
    run_seq("pre_load", 1'b1);
    load = 1'b1; data_in = 8'd7;
    tick();
    load = 1'b0;
    check("load_data", 32'(data_out), 7);
    check("load_tc", 32'(tc), 0);
    check("load_ovf", 32'(ovf), 0);
    load = 1'b1; data_in = 8'd30; en = 1'b0;
    tick();
    load = 1'b0;
    check("load_clamp_data", 32'(data_out), 9);
    check("load_clamp_ovf", 32'(ovf), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    begin_run(9, 1, 0, 1, 20);
    check("start_clamp_data", 32'(data_out), 9);
    check("start_clamp_ovf", 32'(ovf), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("start_clamp_stop_ovf", 32'(ovf), 1);
    begin_run(9, 1, 0, 1, 2);
    check("start_legal_data", 32'(data_out), 2);
    check("start_legal_ovf", 32'(ovf), 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // step 0 advances by 1; start while busy ignored; stop beats en.
    en = 1'b1;
    begin_run(9, 0, 0, 1, 0);
    exp_q    = '{1, 2, 3, 4, 5, 6};
    exp_tc_q = '{0, 0, 0, 0, 0, 0};
    run_seq("step0", 1'b1);
    en = 1'b0; start = 1'b1; data_in = 8'd2; limit = 8'd3; mode = 2'b01;
    tick();
    start = 1'b0;
    check("start_busy_data", 32'(data_out), 6);
    check("start_busy_busy", 32'(busy), 1);
    en = 1'b1;
    tick();
    check("cfg_hold_data", 32'(data_out), 7);
    en = 1'b0;
    load = 1'b1; data_in = 8'd6;
    tick();
    load = 1'b0;
    check("reload6_data", 32'(data_out), 6);
    stop = 1'b1; en = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_en_data", 32'(data_out), 6);
    check("stop_en_busy", 32'(busy), 0);
    check("stop_en_done", 32'(done), 0);
    tick();
    check("stop_idle_data", 32'(data_out), 6);
    check("stop_idle_done", 32'(done), 0);

    // Reset in the middle of a run.
    begin_run(3, 1, 1, 1, 8);
    check("pre_rst_ovf", 32'(ovf), 1);
    tick();
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mid_rst_data", 32'(data_out), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_tc", 32'(tc), 0);
      check("mid_rst_ovf", 32'(ovf), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_cend", 32'(c_end), 1);
    end
    rst = 1'b1; en = 1'b0;
    tick();
    check("post_rst_done", 32'(done), 0);
    check("post_rst_busy", 32'(busy), 0);
    // Latched limit is back to 0, so an IDLE load clamps.
    load = 1'b1; data_in = 8'd5;
    tick();
    load = 1'b0;
    check("post_rst_load_data", 32'(data_out), 0);
    check("post_rst_load_ovf", 32'(ovf), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
